// File: rtl/pipe_skid_stage_pkg.sv
// Shared definitions for the elastic pipeline stage registers: state
// encodings and default bundle widths. Every pipeline boundary uses these.
package pipe_skid_stage_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_FULL  = 2'd1,
        ST_SKID  = 2'd2
    } state_t;

    localparam int CTRL_W_DEF = 16;
    localparam int DATA_W_DEF = 96;
    localparam int PC_W_DEF   = 32;

    // Reset PC sits one word before zero so the first fetch+4 lands on address 0.
    localparam int signed PC_RST_DEF = -4;

endpackage

// File: rtl/pipe_skid_stage_if.sv
// Valid/ready stream carrying one pipeline entry (control, data, PC).
// master drives the entry, slave returns ready.
interface pipe_skid_stage_if #(
    parameter int CTRL_W = 16,
    parameter int DATA_W = 96,
    parameter int PC_W   = 32
);
    logic              valid;
    logic              ready;
    logic [CTRL_W-1:0] ctrl;
    logic [DATA_W-1:0] data;
    logic [PC_W-1:0]   pc;

    modport master (output valid, ctrl, data, pc, input ready);
    modport slave  (input valid, ctrl, data, pc, output ready);
endinterface

// File: rtl/pipe_skid_stage_slot.sv
// One register slot of the stage. clear_ctrl zeroes only the control bundle
// (turning the slot into a bubble) while data/PC keep their last values.
module pipe_skid_stage_slot #(
    parameter int              CTRL_W  = 16,
    parameter int              DATA_W  = 96,
    parameter int              PC_W    = 32,
    parameter logic [PC_W-1:0] PC_INIT = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic              clear_ctrl,
    input  logic [CTRL_W-1:0] d_ctrl,
    input  logic [DATA_W-1:0] d_data,
    input  logic [PC_W-1:0]   d_pc,
    output logic [CTRL_W-1:0] q_ctrl,
    output logic [DATA_W-1:0] q_data,
    output logic [PC_W-1:0]   q_pc
);

    // Slot register: reset > clear_ctrl > load > hold.
    always_ff @(posedge clk) begin
        if (reset) begin
            q_ctrl <= '0;
            q_data <= '0;
            q_pc   <= PC_INIT;
        end else if (clear_ctrl) begin
            q_ctrl <= '0;
        end else if (load) begin
            q_ctrl <= d_ctrl;
            q_data <= d_data;
            q_pc   <= d_pc;
        end
    end

endmodule

// File: rtl/pipe_skid_stage.sv
// Elastic pipeline register with a 2-entry skid buffer, global busy-wait
// stall and flush-to-bubble. Optional stall counter enabled by the macro
// PIPE_STALL_COUNT_EN (adds the stall_count port).
//
// state    | meaning
// ---------+-----------------------------------------------
// ST_EMPTY | no entry held, outputs present a bubble
// ST_FULL  | main slot holds the head entry
// ST_SKID  | main holds head, skid holds the next; no intake
module pipe_skid_stage
    import pipe_skid_stage_pkg::*;
#(
    parameter int        CTRL_W = CTRL_W_DEF,
    parameter int        DATA_W = DATA_W_DEF,
    parameter int        PC_W   = PC_W_DEF,
    parameter int signed PC_RST = PC_RST_DEF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               busy_wait,
    input  logic               flush,
    pipe_skid_stage_if.slave   up,
    pipe_skid_stage_if.master  dn
`ifdef PIPE_STALL_COUNT_EN
    ,
    output logic [31:0]        stall_count
`endif
);

    localparam logic [PC_W-1:0] PC_RST_V = PC_W'(PC_RST);

    state_t state, state_nxt;

    logic in_ready, in_fire, out_valid, out_fire;
    logic main_load_in, main_load_skid, main_clr;
    logic skid_load, skid_clr;

    logic [CTRL_W-1:0] skid_ctrl, main_d_ctrl, main_ctrl;
    logic [DATA_W-1:0] skid_data, main_d_data, main_data;
    logic [PC_W-1:0]   skid_pc,   main_d_pc,   main_pc;

    // in_ready depends only on local state and stall/flush, never on dn.ready.
    assign out_valid = (state != ST_EMPTY);
    assign in_ready  = !busy_wait && !flush && (state != ST_SKID);
    assign in_fire   = up.valid && in_ready;
    assign out_fire  = out_valid && dn.ready && !busy_wait;

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state <= ST_EMPTY;
        else       state <= state_nxt;
    end

    // Next state; busy_wait suppresses both fires, so the state holds.
    always_comb begin
        state_nxt = state;
        if (flush) begin
            state_nxt = ST_EMPTY;
        end else begin
            unique case (state)
                ST_EMPTY: if (in_fire) state_nxt = ST_FULL;
                ST_FULL: begin
                    if (in_fire && !out_fire)      state_nxt = ST_SKID;
                    else if (!in_fire && out_fire) state_nxt = ST_EMPTY;
                end
                ST_SKID:  if (out_fire) state_nxt = ST_FULL;
                default:  state_nxt = ST_EMPTY;
            endcase
        end
    end

    // Slot controls; main ctrl is zeroed whenever the stage goes empty so a
    // bubble always carries ctrl=0.
    always_comb begin
        main_load_in   = 1'b0;
        main_load_skid = 1'b0;
        main_clr       = 1'b0;
        skid_load      = 1'b0;
        skid_clr       = 1'b0;
        if (flush) begin
            main_clr = 1'b1;
            skid_clr = 1'b1;
        end else begin
            unique case (state)
                ST_EMPTY: main_load_in = in_fire;
                ST_FULL: begin
                    main_load_in = in_fire && out_fire;
                    skid_load    = in_fire && !out_fire;
                    main_clr     = !in_fire && out_fire;
                end
                ST_SKID: begin
                    main_load_skid = out_fire;
                    skid_clr       = out_fire;
                end
                default: main_clr = 1'b1;
            endcase
        end
    end

    assign main_d_ctrl = main_load_skid ? skid_ctrl : up.ctrl;
    assign main_d_data = main_load_skid ? skid_data : up.data;
    assign main_d_pc   = main_load_skid ? skid_pc   : up.pc;

    pipe_skid_stage_slot #(
        .CTRL_W (CTRL_W), .DATA_W (DATA_W), .PC_W (PC_W), .PC_INIT (PC_RST_V)
    ) u_main (
        .clk        (clk),
        .reset      (reset),
        .load       (main_load_in || main_load_skid),
        .clear_ctrl (main_clr),
        .d_ctrl     (main_d_ctrl),
        .d_data     (main_d_data),
        .d_pc       (main_d_pc),
        .q_ctrl     (main_ctrl),
        .q_data     (main_data),
        .q_pc       (main_pc)
    );

    pipe_skid_stage_slot #(
        .CTRL_W (CTRL_W), .DATA_W (DATA_W), .PC_W (PC_W), .PC_INIT ('0)
    ) u_skid (
        .clk        (clk),
        .reset      (reset),
        .load       (skid_load),
        .clear_ctrl (skid_clr),
        .d_ctrl     (up.ctrl),
        .d_data     (up.data),
        .d_pc       (up.pc),
        .q_ctrl     (skid_ctrl),
        .q_data     (skid_data),
        .q_pc       (skid_pc)
    );

    assign up.ready = in_ready;
    assign dn.valid = out_valid;
    assign dn.ctrl  = main_ctrl;
    assign dn.data  = main_data;
    assign dn.pc    = main_pc;

`ifdef PIPE_STALL_COUNT_EN
    // Saturating stall counter; only reset clears it, flush does not.
    always_ff @(posedge clk) begin
        if (reset)
            stall_count <= '0;
        else if ((busy_wait || (out_valid && !dn.ready)) && (stall_count != 32'hFFFF_FFFF))
            stall_count <= stall_count + 32'd1;
    end
`endif

endmodule

// File: tb/tb_pipe_skid_stage.sv
// Randomized scoreboard bench for pipe_skid_stage. The reference is a plain
// FIFO of at most two entries: accepted entries are pushed, delivered entries
// popped, flush empties it, busy_wait freezes it.
module tb_pipe_skid_stage;

    localparam int CTRL_W = 16;
    localparam int DATA_W = 96;
    localparam int PC_W   = 32;
    localparam int NCYC   = 3000;

    typedef struct packed {
        logic [CTRL_W-1:0] ctrl;
        logic [DATA_W-1:0] data;
        logic [PC_W-1:0]   pc;
    } entry_t;

    logic clk = 1'b0;
    logic reset, busy_wait, flush;
    always #5 clk = ~clk;

    pipe_skid_stage_if #(.CTRL_W(CTRL_W), .DATA_W(DATA_W), .PC_W(PC_W)) up ();
    pipe_skid_stage_if #(.CTRL_W(CTRL_W), .DATA_W(DATA_W), .PC_W(PC_W)) dn ();

`ifdef PIPE_STALL_COUNT_EN
    logic [31:0] stall_count;
    logic [31:0] exp_stall;
`endif

    pipe_skid_stage #(.CTRL_W(CTRL_W), .DATA_W(DATA_W), .PC_W(PC_W)) dut (
        .clk         (clk),
        .reset       (reset),
        .busy_wait   (busy_wait),
        .flush       (flush),
        .up          (up),
        .dn          (dn)
`ifdef PIPE_STALL_COUNT_EN
        ,
        .stall_count (stall_count)
`endif
    );

    entry_t model_q[$];
    entry_t last_head;
    bit     exp_in_ready;
    bit     run;
    int     errors = 0;
    int     checks = 0;
    int     delivered = 0;

    function automatic void chk(string name, logic [DATA_W-1:0] act, logic [DATA_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    // Monitor: compares the DUT against the FIFO model each cycle, pops on delivery.
    initial begin
        forever begin
            @(negedge clk);
            if (run) begin
                bit exp_valid;
                exp_valid = (model_q.size() > 0);
                chk("in_ready", DATA_W'(up.ready), DATA_W'(exp_in_ready));
                chk("out_valid", DATA_W'(dn.valid), DATA_W'(exp_valid));
`ifdef PIPE_STALL_COUNT_EN
                chk("stall_count", DATA_W'(stall_count), DATA_W'(exp_stall));
                if ((busy_wait || (exp_valid && !dn.ready)) && exp_stall != 32'hFFFF_FFFF)
                    exp_stall++;
`endif
                if (exp_valid) begin
                    last_head = model_q[0];
                    if (dn.ready && !busy_wait) begin
                        chk("head_ctrl", DATA_W'(dn.ctrl), DATA_W'(model_q[0].ctrl));
                        chk("head_data", dn.data, model_q[0].data);
                        chk("head_pc", DATA_W'(dn.pc), DATA_W'(model_q[0].pc));
                        void'(model_q.pop_front());
                        delivered++;
                    end
                end else begin
                    chk("bubble_ctrl", DATA_W'(dn.ctrl), '0);
                    chk("bubble_data_hold", dn.data, last_head.data);
                    chk("bubble_pc_hold", DATA_W'(dn.pc), DATA_W'(last_head.pc));
                end
            end
        end
    end

    // Driver: randomized stimulus, model bookkeeping at each active edge.
    initial begin
        int p_valid, p_ready, p_busy, p_flush;
        logic [PC_W-1:0] pc_next;

        run = 1'b0;
        reset = 1'b1; busy_wait = 1'b0; flush = 1'b0;
        up.valid = 1'b0; up.ctrl = '0; up.data = '0; up.pc = '0;
        dn.ready = 1'b0;
        @(posedge clk); #1;
        chk("rst_out_valid", DATA_W'(dn.valid), '0);
        chk("rst_out_ctrl", DATA_W'(dn.ctrl), '0);
        chk("rst_out_data", dn.data, '0);
        chk("rst_out_pc", DATA_W'(dn.pc), DATA_W'(32'hFFFF_FFFC));
`ifdef PIPE_STALL_COUNT_EN
        chk("rst_stall_count", DATA_W'(stall_count), '0);
        exp_stall = '0;
`endif
        reset = 1'b0;
        #1;
        chk("rst_in_ready", DATA_W'(up.ready), 1);
        last_head = '{ctrl: '0, data: '0, pc: 32'hFFFF_FFFC};
        exp_in_ready = 1'b1;
        pc_next = 32'd8;
        run = 1'b1;

        for (int c = 0; c < NCYC; c++) begin
            // Phases bias toward streaming, back-pressure and stall/flush mixes.
            case ((c / 500) % 3)
                0:       begin p_valid = 90; p_ready = 95; p_busy = 3;  p_flush = 1; end
                1:       begin p_valid = 85; p_ready = 30; p_busy = 5;  p_flush = 4; end
                default: begin p_valid = 60; p_ready = 60; p_busy = 20; p_flush = 8; end
            endcase

            @(posedge clk);
            if (flush)
                model_q.delete();
            else if (up.valid && exp_in_ready)
                model_q.push_back('{ctrl: up.ctrl, data: up.data, pc: up.pc});

            #1;
            if (up.valid && exp_in_ready && !flush) pc_next = pc_next + 32'd4;
            up.valid  = ($urandom_range(99) < p_valid);
            up.ctrl   = CTRL_W'($urandom);
            up.data   = {$urandom, $urandom, $urandom};
            up.pc     = pc_next;
            dn.ready  = ($urandom_range(99) < p_ready);
            busy_wait = ($urandom_range(99) < p_busy);
            flush     = ($urandom_range(99) < p_flush);
            exp_in_ready = !busy_wait && !flush && (model_q.size() < 2);
        end

        @(negedge clk);
        run = 1'b0;
        checks++;
        if (delivered < 500) begin
            errors++;
            $display("FAIL delivered_count: got %0d expected at least 500", delivered);
        end

        // Reset from an arbitrary state returns to the reset values.
        reset = 1'b1;
        @(posedge clk); #1;
        chk("rst2_out_valid", DATA_W'(dn.valid), '0);
        chk("rst2_out_ctrl", DATA_W'(dn.ctrl), '0);
        chk("rst2_out_pc", DATA_W'(dn.pc), DATA_W'(32'hFFFF_FFFC));
`ifdef PIPE_STALL_COUNT_EN
        chk("rst2_stall_count", DATA_W'(stall_count), '0);
`endif
        reset = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
